// File: rtl/brush_rasterizer.sv
`default_nettype none
// ============================================================================
// Module   : brush_rasterizer
// Brief    : Converts one brush-stroke request (centre, colour, size) into a
//            row-major stream of single-pixel frame-buffer writes, sweeping
//            the clipped bounding box of the circle one pixel per clock.
// Revision : 1.0 - initial release
// ============================================================================
module brush_rasterizer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 360,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              stroke_valid_in,
    output logic              stroke_ready_out,
    input  logic [9:0]        x_in,
    input  logic [8:0]        y_in,
    input  logic [3:0]        color_in,
    input  logic [2:0]        sw_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [3:0]        wr_data_out,
    output logic              wr_en_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam logic [10:0]       c_H_RES  = 11'(H_RES);
    localparam logic [10:0]       c_X_LAST = 11'(H_RES - 1);
    localparam logic [9:0]        c_V_RES  = 10'(V_RES);
    localparam logic [9:0]        c_Y_LAST = 10'(V_RES - 1);
    localparam logic [ADDR_W-1:0] c_ROW    = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [3:0]         r_wr_data;

    // Latched stroke and sweep position
    logic [9:0]         r_cx;
    logic [8:0]         r_cy;
    logic [3:0]         r_r;
    logic [3:0]         r_color;
    logic [9:0]         r_xmin;
    logic [9:0]         r_xmax;
    logic [8:0]         r_ymax;
    logic [9:0]         r_px;
    logic [8:0]         r_py;
    logic [ADDR_W-1:0]  r_addr;

    // Request-side bounding box (only meaningful at the accept edge)
    logic [3:0]         w_r;
    logic [9:0]         w_xmin;
    logic [10:0]        w_xsum;
    logic [9:0]         w_xmax;
    logic [8:0]         w_ymin;
    logic [9:0]         w_ysum;
    logic [8:0]         w_ymax;
    logic               w_off;
    logic [ADDR_W-1:0]  w_base;
    logic               w_accept;

    // Sweep-side circle test and stepping
    logic [10:0]        w_dx_full;
    logic [9:0]         w_dy_full;
    logic [5:0]         w_dx;
    logic [5:0]         w_dy;
    logic [4:0]         w_adx;
    logic [4:0]         w_ady;
    logic [9:0]         w_dist;
    logic [9:0]         w_r2;
    logic               w_inside;
    logic               w_row_end;
    logic               w_last;
    logic [ADDR_W-1:0]  w_row_step;

    // Radius is always odd: 2*sw+1. Box edges are computed one bit wider so
    // the low side cannot wrap and the high side can be clipped to the canvas.
    assign w_r      = {sw_in, 1'b1};
    assign w_xmin   = (x_in >= {6'd0, w_r}) ? (x_in - {6'd0, w_r}) : 10'd0;
    assign w_xsum   = {1'b0, x_in} + {7'd0, w_r};
    assign w_xmax   = (w_xsum > c_X_LAST) ? c_X_LAST[9:0] : w_xsum[9:0];
    assign w_ymin   = (y_in >= {5'd0, w_r}) ? (y_in - {5'd0, w_r}) : 9'd0;
    assign w_ysum   = {1'b0, y_in} + {6'd0, w_r};
    assign w_ymax   = (w_ysum > c_Y_LAST) ? c_Y_LAST[8:0] : w_ysum[8:0];
    assign w_off    = ({1'b0, x_in} >= c_H_RES) || ({1'b0, y_in} >= c_V_RES);
    // Single multiply per stroke; the sweep itself only adds.
    assign w_base   = ADDR_W'(w_ymin) * c_ROW + ADDR_W'(w_xmin);
    assign w_accept = stroke_valid_in && r_ready;

    // Inside the box |dx|,|dy| <= 15, so 6-bit two's complement is enough.
    assign w_dx_full  = {1'b0, r_px} - {1'b0, r_cx};
    assign w_dy_full  = {1'b0, r_py} - {1'b0, r_cy};
    assign w_dx       = w_dx_full[5:0];
    assign w_dy       = w_dy_full[5:0];
    assign w_adx      = w_dx[5] ? (~w_dx[4:0] + 5'd1) : w_dx[4:0];
    assign w_ady      = w_dy[5] ? (~w_dy[4:0] + 5'd1) : w_dy[4:0];
    assign w_dist     = {5'd0, w_adx} * {5'd0, w_adx} + {5'd0, w_ady} * {5'd0, w_ady};
    assign w_r2       = {6'd0, r_r} * {6'd0, r_r};
    assign w_inside   = (w_dist <= w_r2);
    assign w_row_end  = (r_px == r_xmax);
    assign w_last     = w_row_end && (r_py == r_ymax);
    assign w_row_step = c_ROW - ADDR_W'(r_xmax - r_xmin);

    // Stroke FSM: handshake, box sweep and registered write-port outputs
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 4'd0;
            r_cx      <= 10'd0;
            r_cy      <= 9'd0;
            r_r       <= 4'd0;
            r_color   <= 4'd0;
            r_xmin    <= 10'd0;
            r_xmax    <= 10'd0;
            r_ymax    <= 9'd0;
            r_px      <= 10'd0;
            r_py      <= 9'd0;
            r_addr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cx    <= x_in;
                        r_cy    <= y_in;
                        r_r     <= w_r;
                        r_color <= color_in;
                        r_xmin  <= w_xmin;
                        r_xmax  <= w_xmax;
                        r_ymax  <= w_ymax;
                        r_px    <= w_xmin;
                        r_py    <= w_ymin;
                        r_addr  <= w_base;
                        r_state <= w_off ? S_FIN : S_SCAN;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Address always advances; only the strobe is gated.
                    r_wr_en   <= w_inside;
                    r_wr_addr <= r_addr;
                    r_wr_data <= r_color;
                    if (w_row_end) begin
                        r_px   <= r_xmin;
                        r_py   <= r_py + 9'd1;
                        r_addr <= r_addr + w_row_step;
                    end else begin
                        r_px   <= r_px + 10'd1;
                        r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    if (w_last) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    // Last write slot is on the port now; signal completion next.
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stroke_ready_out = r_ready;
    assign busy_out         = r_busy;
    assign done_out         = r_done;
    assign wr_en_out        = r_wr_en;
    assign wr_addr_out      = r_wr_addr;
    assign wr_data_out      = r_wr_data;

endmodule
`default_nettype wire

// File: doc/brush_rasterizer.md
Name: brush_rasterizer

Overview:
- Turns one brush-stroke request (centre, colour, size switch) into a stream of single-pixel writes for the canvas frame buffer write port.
- Sits between the brush tracker and the frame-buffer RAM port. It replaces the per-pixel circle test on the raster scan with a dedicated bounding-box sweep.
- Produces one candidate pixel per clock, row-major. A write enable is asserted only for pixels inside the circle.

Parameters:
- H_RES, 640, canvas width in pixels; address = x + H_RES*y.
- V_RES, 360, canvas height in pixels.
- ADDR_W, $clog2(H_RES*V_RES) = 18, write-address width.

Ports:
- pixel_clk_in  input  1  sole clock, all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- stroke_valid_in  input  1  request present.
- stroke_ready_out  output  1  block can accept a request.
- x_in  input  10  brush centre x.
- y_in  input  9  brush centre y.
- color_in  input  4  palette index to write.
- sw_in  input  3  size select; radius r = 2*sw_in+1 (1..15).
- wr_addr_out  output  ADDR_W  frame-buffer write address.
- wr_data_out  output  4  colour for wr_addr_out.
- wr_en_out  output  1  write strobe, one pixel per cycle.
- busy_out  output  1  sweep in progress.
- done_out  output  1  one-cycle pulse at end of each accepted stroke.

Behaviour:
- Reset (rst_in low, async):
  - state=IDLE.
  - stroke_ready_out=0, wr_en_out=0, wr_addr_out=0, wr_data_out=0, busy_out=0, done_out=0.
  - stroke_ready_out rises on the first clock edge after release.
- All outputs are registered.
- Handshake:
  - Accept on an edge where stroke_valid_in && stroke_ready_out.
  - x, y, colour and r are latched at that edge. Later input changes are ignored until the next acceptance.
  - stroke_ready_out=1 only in IDLE; it drops the cycle after acceptance.
  - A request held valid while busy waits; it is never dropped or merged.
- States:
  - IDLE -> SCAN on accept.
  - IDLE -> FIN on accept when x_in>=H_RES or y_in>=V_RES (off-canvas: no writes).
  - SCAN -> FIN after the last box pixel is evaluated.
  - FIN -> IDLE after one cycle.
- Bounding box, unsigned arithmetic, widened one bit to avoid underflow:
  - xmin=max(0,x-r), xmax=min(H_RES-1,x+r).
  - ymin=max(0,y-r), ymax=min(V_RES-1,y+r).
- Sweep order:
  - Starts at (xmin,ymin); x increments each cycle.
  - At xmax, x wraps to xmin and y increments. Ends after (xmax,ymax).
  - SCAN therefore lasts (xmax-xmin+1)*(ymax-ymin+1) cycles. Unclipped: 9 cycles for sw=0, 961 for sw=7.
- Inside test:
  - (px-x)^2+(py-y)^2 <= r^2, using signed differences of at most 6 bits and an unsigned compare at least 9 bits wide.
  - Boundary pixels are included.
- Address:
  - Maintained incrementally: +1 per x step; +H_RES-(xmax-xmin) on row wrap.
  - The row base is computed once at accept. No per-pixel multiply by H_RES.
- Latency:
  - The pixel evaluated in SCAN cycle k appears on wr_addr_out/wr_data_out with wr_en_out in cycle k+1.
  - wr_en_out=0 for outside pixels, but the address still advances.
- Completion:
  - busy_out=1 from the cycle after accept through the cycle carrying the last write.
  - done_out pulses in the cycle after the last write slot.
  - stroke_ready_out=1 again the cycle after done_out.
  - An off-canvas stroke: busy_out for 1 cycle, no wr_en_out, done_out pulse.
- Reset mid-sweep: immediate abort and return to the reset values above; no done_out pulse.

Test Plan:
- sw=0 at (100,50) -> 9 SCAN cycles, exactly 5 wr_en_out pulses, in order: addr 31460, 32099, 32100, 32101, 32740, each with wr_data_out=color_in. Then one done_out pulse.
- sw=1 at (0,0), colour 3 -> box 4x4 = 16 cycles, 11 writes. First write at addr 0. No address ever exceeds row 3 / column 3.
- sw=0 at (639,359) -> 4 cycles; writes at 229759, 230398, 230399. No address >= 230400.
- Second request held valid during a sw=7 sweep -> not accepted until the cycle after done_out. Each stroke yields its own done_out, and the second uses its own colour.
- x_in=700, y_in=10 -> accepted, zero wr_en_out, a single done_out pulse 2 cycles after accept.
- rst_in low at SCAN cycle 20 of a sw=7 stroke -> wr_en_out and busy_out go to 0 without a clock edge. No done_out. stroke_ready_out=1 one edge after release, and a new stroke then runs normally.
